// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
// Imported by the interface, the debounce block and the scheduler top.
package seven_seg_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    ALERT = 1'b1
  } state_e;

  localparam logic [15:0] DISP_BLANK = 16'h0000;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned src_w(input int unsigned num_src);
    return cnt_w(num_src);
  endfunction

endpackage

// File: rtl/seven_seg_scheduler_if.sv
// Requester/display bundle between the datapath sources and the scheduler.
// The master side owns the sources and alert request; the slave side is the scheduler.
interface seven_seg_scheduler_if
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) ();

  localparam int unsigned SRC_W = src_w(NUM_SRC);

  logic [16*NUM_SRC-1:0] src_value;
  logic [NUM_SRC-1:0]    src_valid;
  logic                  alert_req;
  logic [15:0]           alert_value;
  logic                  alert_ack;
  logic [7:0]            disp_a;
  logic [7:0]            disp_b;
  logic [SRC_W-1:0]      cur_src;
  logic                  blank;
  logic                  alert_active;

  modport master (
    output src_value,
    output src_valid,
    output alert_req,
    output alert_value,
    input  alert_ack,
    input  disp_a,
    input  disp_b,
    input  cur_src,
    input  blank,
    input  alert_active
  );

  modport slave (
    input  src_value,
    input  src_valid,
    input  alert_req,
    input  alert_value,
    output alert_ack,
    output disp_a,
    output disp_b,
    output cur_src,
    output blank,
    output alert_active
  );

endinterface

// File: rtl/seven_seg_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on each debounced rising edge.
module seven_seg_debounce
  import seven_seg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = cnt_w(DEBOUNCE_CYCLES);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Any cycle where the synchronized level agrees with the debounced one restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/seven_seg_scheduler.sv
// Shares the 4-digit display between NUM_SRC requesters: timed or button rotation
// over valid sources, with a one-shot alert that pre-empts rotation for a fixed hold.
module seven_seg_scheduler
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned DWELL_CYCLES    = 100000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset_n,
  input  logic                  auto_mode,
  input  logic                  next_btn,
  seven_seg_scheduler_if.slave  bus
);

  localparam int unsigned SRC_W  = src_w(NUM_SRC);
  localparam int unsigned DwellW = cnt_w(DWELL_CYCLES);
  localparam int unsigned HoldW  = cnt_w(HOLD_CYCLES);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   cur_src_q, cur_src_d;
  logic [DwellW-1:0]  dwell_q, dwell_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [15:0]        alert_val_q, alert_val_d;
  logic               alert_ack_q, alert_ack_d;
  logic               alert_active_q, alert_active_d;
  logic [15:0]        disp_q, disp_d;
  logic               blank_q, blank_d;

  logic               press;
  logic [SRC_W-1:0]   next_src;

  seven_seg_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (clock_100Mhz),
    .rst_ni (reset_n),
    .btn_i  (next_btn),
    .press_o(press)
  );

  // Round robin from cur+1; returns cur unchanged when no other source is valid.
  function automatic logic [SRC_W-1:0] find_next(input logic [SRC_W-1:0] cur,
                                                 input logic [NUM_SRC-1:0] valid);
    logic [SRC_W-1:0] res;
    logic             found;
    int unsigned      sum;
    res   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k < NUM_SRC; k++) begin
      sum = 32'(cur) + k;
      if (sum >= NUM_SRC) begin
        sum = sum - NUM_SRC;
      end
      if (!found && valid[SRC_W'(sum)]) begin
        res   = SRC_W'(sum);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign next_src = find_next(cur_src_q, bus.src_valid);

  always_comb begin
    state_d        = state_q;
    cur_src_d      = cur_src_q;
    dwell_d        = dwell_q;
    hold_d         = hold_q;
    alert_val_d    = alert_val_q;
    alert_ack_d    = 1'b0;
    alert_active_d = alert_active_q;

    unique case (state_q)
      SHOW: begin
        // Alert has priority; a coincident dwell expiry or press is dropped.
        if (bus.alert_req) begin
          state_d        = ALERT;
          alert_ack_d    = 1'b1;
          alert_active_d = 1'b1;
          alert_val_d    = bus.alert_value;
          hold_d         = '0;
          dwell_d        = '0;
        end else if (press) begin
          cur_src_d = next_src;
          dwell_d   = '0;
        end else if (auto_mode) begin
          if (dwell_q == DwellW'(DWELL_CYCLES - 1)) begin
            cur_src_d = next_src;
            dwell_d   = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      ALERT: begin
        if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d        = SHOW;
          alert_active_d = 1'b0;
          hold_d         = '0;
          dwell_d        = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = SHOW;
      end
    endcase
  end

  // Display follows the current state/selection, one cycle behind it.
  always_comb begin
    disp_d  = DISP_BLANK;
    blank_d = 1'b1;
    unique case (state_q)
      SHOW: begin
        if (bus.src_valid[cur_src_q]) begin
          disp_d  = bus.src_value[{cur_src_q, 4'b0000} +: 16];
          blank_d = 1'b0;
        end
      end
      ALERT: begin
        disp_d  = alert_val_q;
        blank_d = 1'b0;
      end
      default: begin
        disp_d  = DISP_BLANK;
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= SHOW;
      cur_src_q      <= '0;
      dwell_q        <= '0;
      hold_q         <= '0;
      alert_val_q    <= DISP_BLANK;
      alert_ack_q    <= 1'b0;
      alert_active_q <= 1'b0;
      disp_q         <= DISP_BLANK;
      blank_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      cur_src_q      <= cur_src_d;
      dwell_q        <= dwell_d;
      hold_q         <= hold_d;
      alert_val_q    <= alert_val_d;
      alert_ack_q    <= alert_ack_d;
      alert_active_q <= alert_active_d;
      disp_q         <= disp_d;
      blank_q        <= blank_d;
    end
  end

  assign bus.alert_ack    = alert_ack_q;
  assign bus.alert_active = alert_active_q;
  assign bus.cur_src      = cur_src_q;
  assign bus.disp_a       = disp_q[15:8];
  assign bus.disp_b       = disp_q[7:0];
  assign bus.blank        = blank_q;

endmodule

// File: tb/tb_seven_seg_scheduler.sv
// Directed bench for seven_seg_scheduler with NUM_SRC=4, DWELL=8, HOLD=5, DEBOUNCE=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_seven_seg_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic auto_mode;
  logic next_btn;

  int total = 0;
  int bad   = 0;

  logic [15:0] vals [4];

  seven_seg_scheduler_if #(.NUM_SRC(4)) bus ();

  seven_seg_scheduler #(
    .NUM_SRC        (4),
    .DWELL_CYCLES   (8),
    .HOLD_CYCLES    (5),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clock_100Mhz(clk),
    .reset_n     (rst_n),
    .auto_mode   (auto_mode),
    .next_btn    (next_btn),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [15:0] exp_v, input logic exp_blank);
    chk({tag, "_disp"}, 32'({bus.disp_a, bus.disp_b}), 32'(exp_v));
    chk({tag, "_blank"}, 32'(bus.blank), 32'(exp_blank));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vals[0] = 16'h1234;
    vals[1] = 16'h5678;
    vals[2] = 16'h9ABC;
    vals[3] = 16'hDEF0;

    rst_n           = 1'b0;
    auto_mode       = 1'b0;
    next_btn        = 1'b0;
    bus.src_value   = {vals[3], vals[2], vals[1], vals[0]};
    bus.src_valid   = 4'b1111;
    bus.alert_req   = 1'b0;
    bus.alert_value = 16'h0000;

    // Reset state
    tick(2);
    chk_disp("rst", 16'h0000, 1'b1);
    chk("rst_cur", 32'(bus.cur_src), 0);
    chk("rst_active", 32'(bus.alert_active), 0);
    chk("rst_ack", 32'(bus.alert_ack), 0);

    rst_n = 1'b1;
    tick(1);
    chk_disp("first", 16'h1234, 1'b0);

    // Auto rotation: one step every 8 clocks, display one clock behind
    auto_mode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk_disp("rot_val", vals[(i - 1) % 4], 1'b0);
      tick(6);
      chk("rot_hold", 32'(bus.cur_src), 32'((i - 1) % 4));
      tick(1);
      chk("rot_step", 32'(bus.cur_src), 32'(i % 4));
    end

    // Skip invalid sources, then nothing valid
    bus.src_valid = 4'b1010;
    tick(1);
    chk_disp("skip_inv0", 16'h0000, 1'b1);
    tick(7);
    chk("skip_to1", 32'(bus.cur_src), 1);
    tick(8);
    chk("skip_to3", 32'(bus.cur_src), 3);
    tick(8);
    chk("skip_wrap1", 32'(bus.cur_src), 1);
    tick(1);
    chk_disp("skip_val1", 16'h5678, 1'b0);
    bus.src_valid = 4'b0000;
    tick(1);
    chk_disp("none", 16'h0000, 1'b1);
    tick(7);
    chk("none_hold", 32'(bus.cur_src), 1);
    chk("none_blank", 32'(bus.blank), 1);

    // Debounce: 2-clock glitch ignored, long press advances exactly once
    auto_mode     = 1'b0;
    bus.src_valid = 4'b1111;
    next_btn      = 1'b1;
    tick(2);
    next_btn = 1'b0;
    tick(6);
    chk("glitch", 32'(bus.cur_src), 1);
    next_btn = 1'b1;
    tick(5);
    chk("press_early", 32'(bus.cur_src), 1);
    tick(1);
    chk("press_adv", 32'(bus.cur_src), 2);
    tick(4);
    next_btn = 1'b0;
    chk("press_once", 32'(bus.cur_src), 2);
    tick(10);
    chk("release", 32'(bus.cur_src), 2);

    // Alert on the dwell-expiry edge; a press lands mid-alert and is discarded
    auto_mode = 1'b1;
    tick(5);
    next_btn = 1'b1;
    tick(2);
    bus.alert_req   = 1'b1;
    bus.alert_value = 16'hDEAD;
    tick(1);
    chk("alert_ack", 32'(bus.alert_ack), 1);
    chk("alert_cur", 32'(bus.cur_src), 2);
    chk("alert_act", 32'(bus.alert_active), 1);
    chk_disp("alert_lag", 16'h9ABC, 1'b0);
    bus.alert_req = 1'b0;
    tick(1);
    chk("alert_ack_off", 32'(bus.alert_ack), 0);
    chk_disp("alert_q1", 16'hDEAD, 1'b0);
    tick(3);
    chk_disp("alert_q4", 16'hDEAD, 1'b0);
    chk("alert_q4_cur", 32'(bus.cur_src), 2);
    tick(1);
    chk("alert_end_act", 32'(bus.alert_active), 0);
    chk_disp("alert_q5", 16'hDEAD, 1'b0);
    chk("alert_end_cur", 32'(bus.cur_src), 2);
    tick(1);
    chk_disp("alert_back", 16'h9ABC, 1'b0);
    next_btn = 1'b0;
    tick(6);
    chk("dwell_restart_hold", 32'(bus.cur_src), 2);
    tick(1);
    chk("dwell_restart_step", 32'(bus.cur_src), 3);

    // Reset asserted at hold count 2
    bus.alert_req   = 1'b1;
    bus.alert_value = 16'hBEEF;
    tick(1);
    chk("alert2_ack", 32'(bus.alert_ack), 1);
    bus.alert_req = 1'b0;
    tick(2);
    chk_disp("alert2_show", 16'hBEEF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_act", 32'(bus.alert_active), 0);
    chk("mid_rst_cur", 32'(bus.cur_src), 0);
    chk_disp("mid_rst", 16'h0000, 1'b1);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk_disp("after_rst", 16'h1234, 1'b0);
    chk("after_rst_act", 32'(bus.alert_active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scheduler.md
Name: seven_seg_scheduler

Overview:
- Decides what the 4-digit seven-segment display driver shows by sharing it between up to NUM_SRC 16-bit requesters, e.g. accumulator/register pairs, address bus, data bus and flags.
- Rotates through valid sources automatically on a dwell timer, or on a debounced push-button.
- A one-shot alert requester pre-empts the rotation for a fixed hold time.
- Sits between the 8085 datapath and the display driver: disp_a feeds the driver's upper two digits, disp_b its lower two.

Parameters:
- NUM_SRC, 4, number of display requesters (2..8).
- DWELL_CYCLES, 100000000, auto-rotate period in clocks (≥2).
- HOLD_CYCLES, 50000000, alert display duration in clocks (≥1).
- DEBOUNCE_CYCLES, 1000000, clocks next_btn must be stable to register (≥1).

Ports:
- clock_100Mhz  in  1  100 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- src_value  in  16*NUM_SRC  source i on bits [16i+15:16i].
- src_valid  in  NUM_SRC  source i may be displayed.
- auto_mode  in  1  1 = timed rotation, 0 = button only.
- next_btn  in  1  raw asynchronous push-button.
- alert_req  in  1  level request to show alert_value.
- alert_value  in  16  value sampled when an alert is accepted.
- alert_ack  out  1  one-cycle pulse when an alert is accepted.
- disp_a  out  8  high byte to display driver.
- disp_b  out  8  low byte to display driver.
- cur_src  out  $clog2(NUM_SRC)  index of the selected source.
- blank  out  1  1 = display has nothing valid; top gates the anodes.
- alert_active  out  1  1 while in ALERT.

Behaviour:
- Clock and reset: one clock, clock_100Mhz; reset is asynchronous and active-low on reset_n.
- Reset values: state=SHOW, cur_src=0, disp_a=disp_b=0, blank=1, alert_ack=0, alert_active=0. Dwell, hold and debounce counters are 0; synchronizer and debounced level are 0.
- Reset is honoured mid-anything, including mid-alert and mid-debounce.
- States: SHOW and ALERT.
- Display path, registered, one cycle behind state/cur_src:
  - SHOW with src_valid[cur_src]=1: {disp_a,disp_b} = src_value[cur_src], blank=0.
  - SHOW with src_valid[cur_src]=0: disp=0, blank=1.
  - ALERT: disp = latched alert value, blank=0.
- Next-source search: round robin starting at cur_src+1, wrapping modulo NUM_SRC, first index with src_valid=1, resolved in the same cycle.
  - If no other source is valid, cur_src holds.
  - If no source is valid, cur_src holds and blank=1.
- Dwell counter: increments every cycle in SHOW when auto_mode=1, and holds when auto_mode=0.
  - At DWELL_CYCLES-1 it advances cur_src and clears to 0.
  - Rotation period is exactly DWELL_CYCLES clocks.
- Button path: next_btn goes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks.
  - A debounced rising edge produces a one-cycle press pulse.
  - In SHOW, press advances cur_src and clears the dwell counter, in either mode.
  - Presses during ALERT are discarded.
- Alert acceptance: in SHOW with alert_req=1 at a clock edge:
  - state←ALERT, alert_ack←1 for one cycle, alert_active←1, alert_value latched, hold counter←0.
  - Alert wins over a simultaneous dwell expiry or press; that advance is dropped and the dwell counter clears.
- ALERT:
  - alert_req is ignored (no ack).
  - The hold counter counts to HOLD_CYCLES-1, then state←SHOW with cur_src unchanged and the dwell counter at 0.
  - If alert_req is still high on the first SHOW cycle, a new alert is accepted (new ack).
  - Requesters must drop alert_req after ack.
- Changes in src_valid or src_value are reflected on the next clock; no holding of stale values.
- Counter widths: $clog2 of each bound, no overflow paths.

Decomposition:
- Package seven_seg_pkg:
  - state enum {SHOW, ALERT};
  - SRC_W = $clog2(NUM_SRC) helper;
  - DISP_BLANK = 16'h0000 constant.
- Sub-module seven_seg_debounce: synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES.
- The scheduler FSM, search and output registers live in seven_seg_scheduler.

Test Plan:
- All scenarios use NUM_SRC=4, DWELL=8, HOLD=5, DEBOUNCE=3.
- Reset/first value: reset_n low with src_valid=4'b1111, src0=0x1234 → disp 00/00, blank=1, cur_src=0. Release → disp_a=0x12, disp_b=0x34, blank=0 after one clock.
- Auto rotation: auto_mode=1, all valid → cur_src 0→1→2→3→0, one step every 8 clocks exactly. disp follows one cycle later.
- Skip/blank: src_valid=4'b1010, cur_src=1 → next 3, then 1. Then src_valid=0 → blank=1, disp 00/00, cur_src holds.
- Debounce: auto_mode=0, next_btn high 2 clocks → no advance. next_btn high 10 clocks → exactly one advance, at the 3rd stable synchronized cycle + edge pulse.
- Alert pre-emption: alert_req=1 with alert_value=0xDEAD on the dwell-expiry edge → alert_ack single pulse, cur_src unchanged, disp DE/AD for 5 clocks, then back to the source with dwell restarted. Button press during the alert has no effect.
- Reset mid-alert: reset_n low on hold count 2 → immediate reset values, alert_active=0. After release, SHOW with src0.
